// File: rtl/cryptoatm_disp_pkg.sv
// Shared widths, letter codes and the 7-segment glyph table for the instruction display.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package cryptoatm_disp_pkg;

  localparam int CHAR_W   = 5;
  localparam int N_DIGITS = 8;
  localparam int WORD_W   = CHAR_W * N_DIGITS;

  typedef enum logic [CHAR_W-1:0] {
    CH_BLANK, CH_A, CH_B, CH_C, CH_D, CH_E, CH_F, CH_G, CH_H, CH_I,
    CH_J, CH_K, CH_L, CH_M, CH_N, CH_O, CH_P, CH_Q, CH_R, CH_S,
    CH_T, CH_U, CH_V, CH_W, CH_X, CH_Y, CH_Z, CH_DASH
  } letter_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [6:0] seg_lookup(input logic [CHAR_W-1:0] code);
    logic [6:0] pat;
    case (code)
      5'd1:    pat = 7'h08; // A
      5'd2:    pat = 7'h03; // b
      5'd3:    pat = 7'h46; // C
      5'd4:    pat = 7'h21; // d
      5'd5:    pat = 7'h06; // E
      5'd6:    pat = 7'h0E; // F
      5'd7:    pat = 7'h42; // G
      5'd8:    pat = 7'h09; // H
      5'd9:    pat = 7'h79; // I
      5'd10:   pat = 7'h61; // J
      5'd11:   pat = 7'h0A; // K (approximation)
      5'd12:   pat = 7'h47; // L
      5'd13:   pat = 7'h6A; // M (approximation)
      5'd14:   pat = 7'h2B; // n
      5'd15:   pat = 7'h40; // O
      5'd16:   pat = 7'h0C; // P
      5'd17:   pat = 7'h18; // q
      5'd18:   pat = 7'h2F; // r
      5'd19:   pat = 7'h12; // S
      5'd20:   pat = 7'h07; // t
      5'd21:   pat = 7'h41; // U
      5'd22:   pat = 7'h63; // v (approximation)
      5'd23:   pat = 7'h55; // W (approximation)
      5'd24:   pat = 7'h09; // X shares H
      5'd25:   pat = 7'h11; // y
      5'd26:   pat = 7'h24; // Z
      5'd27:   pat = SEG_DASH;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/inst_display_scanner_letter_to_seg.sv
// Combinational letter-code to active-low segment pattern decoder.
module letter_to_seg
  import cryptoatm_disp_pkg::*;
(
  input  logic [CHAR_W-1:0] code,
  output logic [6:0]        seg
);

  always_comb seg = seg_lookup(code);

endmodule

// File: rtl/inst_display_scanner.sv
// Time-multiplexed 8-digit display scanner with tear-free capture of the instruction word.
// Optional whole-display flashing is built only when INST_DISP_BLINK_EN is defined.
module inst_display_scanner
  import cryptoatm_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 250
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [WORD_W-1:0]   instruction,
  input  logic                enable,
  input  logic                blink,
  output logic [N_DIGITS-1:0] an,
  output logic [6:0]          seg
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(N_DIGITS);

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_next;
  logic [WORD_W-1:0]   shadow;
  logic                tick;
  logic [CHAR_W-1:0]   cur_code;
  logic [6:0]          cur_seg;
  logic [N_DIGITS-1:0] scan_an;
  logic                an_dark;

  // Digit 0 reads the live word on the wrap tick, the same value shadow captures then.
  always_comb begin
    tick     = enable && (cnt == CNT_W'(REFRESH_DIV - 1));
    idx_next = idx + 1'b1;
    cur_code = (idx == IDX_W'(N_DIGITS - 1)) ? instruction[CHAR_W-1:0]
                                             : shadow[idx_next*CHAR_W +: CHAR_W];
    scan_an  = ~(N_DIGITS'(1) << idx_next);
  end

  letter_to_seg u_dec (
    .code (cur_code),
    .seg  (cur_seg)
  );

`ifdef INST_DISP_BLINK_EN
  localparam int unsigned BC_W = $clog2(BLINK_DIV + 1);

  logic [BC_W-1:0] bcnt;
  logic            phase_on;

  always_ff @(posedge clock) begin
    if (!rst || !blink) begin
      bcnt     <= '0;
      phase_on <= 1'b1;
    end else if (tick) begin
      if (bcnt == BC_W'(BLINK_DIV - 1)) begin
        bcnt     <= '0;
        phase_on <= ~phase_on;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  always_comb an_dark = blink && !phase_on;
`else
  logic unused_blink;

  always_comb begin
    unused_blink = blink;
    an_dark      = 1'b0;
  end
`endif

  always_ff @(posedge clock) begin
    if (!rst) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      an     <= '1;
      seg    <= SEG_BLANK;
    end else if (!enable) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= idx_next;
        an  <= an_dark ? '1 : scan_an;
        seg <= cur_seg;
        if (idx == IDX_W'(N_DIGITS - 1))
          shadow <= instruction;
      end
    end
  end

endmodule

// File: tb/tb_inst_display_scanner.sv
// Directed bench for inst_display_scanner with REFRESH_DIV=4, BLINK_DIV=2.
module tb_inst_display_scanner;
  import cryptoatm_disp_pkg::*;

  logic        clock = 1'b0;
  logic        rst;
  logic [39:0] instruction;
  logic        enable;
  logic        blink;
  logic [7:0]  an;
  logic [6:0]  seg;

  int n_pass  = 0;
  int n_total = 0;

  inst_display_scanner #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (
    .clock       (clock),
    .rst         (rst),
    .instruction (instruction),
    .enable      (enable),
    .blink       (blink),
    .an          (an),
    .seg         (seg)
  );

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic tick_step();
    step(4);
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_digit(input string tag, input logic [7:0] ea, input logic [6:0] es);
    check({tag, "_an"}, an, ea);
    check({tag, "_seg"}, {1'b0, seg}, {1'b0, es});
  endtask

  initial begin
    logic [7:0] ea;
    rst = 1'b0; enable = 1'b0; blink = 1'b0; instruction = '0;
    step(3);
    check_digit("reset", 8'hFF, 7'h7F);

    rst = 1'b1; enable = 1'b1;
    step(3);
    check("pre_tick_an", an, 8'hFF);
    step(1);
    check_digit("first_tick", 8'hFD, 7'h7F);

    // Scan order
    instruction = {CH_U, CH_S, CH_D, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_A};
    repeat (6) tick_step();
    check_digit("d7_old_shadow", 8'h7F, 7'h7F);
    tick_step(); check_digit("scan_d0", 8'hFE, 7'h08);
    for (int d = 1; d <= 4; d++) begin
      tick_step();
      ea = ~(8'h01 << d);
      check_digit("scan_blank", ea, 7'h7F);
    end
    tick_step(); check_digit("scan_d5", 8'hDF, 7'h21);
    tick_step(); check_digit("scan_d6", 8'hBF, 7'h12);
    tick_step(); check_digit("scan_d7", 8'h7F, 7'h41);

    // Tear-free capture
    tick_step(); check_digit("tf_d0", 8'hFE, 7'h08);
    tick_step(); tick_step(); tick_step();
    check_digit("tf_d3", 8'hF7, 7'h7F);
    instruction = {8{CH_T}};
    tick_step(); check_digit("tf_d4_old", 8'hEF, 7'h7F);
    tick_step(); check_digit("tf_d5_old", 8'hDF, 7'h21);
    tick_step(); check_digit("tf_d6_old", 8'hBF, 7'h12);
    tick_step(); check_digit("tf_d7_old", 8'h7F, 7'h41);
    tick_step(); check_digit("tf_d0_new", 8'hFE, 7'h07);
    tick_step(); check_digit("tf_d1_new", 8'hFD, 7'h07);

    // Enable hold
    repeat (4) tick_step();
    check_digit("en_d5", 8'hDF, 7'h07);
    enable = 1'b0;
    step(1);
    check_digit("en_off", 8'hFF, 7'h7F);
    step(9);
    check_digit("en_off_hold", 8'hFF, 7'h7F);
    enable = 1'b1;
    step(3);
    check("en_resume_wait", an, 8'hFF);
    step(1);
    check_digit("en_resume_d6", 8'hBF, 7'h07);

    // Codes 27..31
    instruction = {15'd0, 5'd31, 5'd30, 5'd29, 5'd28, 5'd27};
    tick_step(); check_digit("code_d7", 8'h7F, 7'h07);
    tick_step(); check_digit("code27", 8'hFE, 7'h3F);
    for (int d = 1; d <= 4; d++) begin
      tick_step();
      ea = ~(8'h01 << d);
      check_digit("code28_31", ea, 7'h7F);
    end
    tick_step(); check_digit("code_d5", 8'hDF, 7'h7F);

    // Blink
    blink = 1'b1;
    tick_step(); check("blink_d6", an, 8'hBF);
    tick_step(); check("blink_d7", an, 8'h7F);
`ifdef INST_DISP_BLINK_EN
    tick_step(); check("blink_dark0", an, 8'hFF);
    tick_step(); check("blink_dark1", an, 8'hFF);
`else
    tick_step(); check("blink_ign_d0", an, 8'hFE);
    tick_step(); check("blink_ign_d1", an, 8'hFD);
`endif
    tick_step(); check("blink_d2", an, 8'hFB);
    blink = 1'b0;
    tick_step(); check("blink_off_d3", an, 8'hF7);

    // Reset mid-frame
    step(2);
    rst = 1'b0;
    step(1);
    check_digit("mid_reset", 8'hFF, 7'h7F);
    rst = 1'b1;
    step(4);
    check_digit("mid_reset_tick", 8'hFD, 7'h7F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
